// File: rtl/run_ctrl.sv
// Run controller: stretches the external reset into a fixed-length core reset,
// counts RUN cycles and latches a sticky terminal state on halt, error or watchdog.
module run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100004,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst,
  input  logic             err,
  input  logic             halt,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             err_flag,
  output logic             timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int RC_W = $clog2(RST_CYCLES) + 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_RUN     = 3'd1,
    S_HALT    = 3'd2,
    S_ERROR   = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             err_flag_q, err_flag_d;
  logic             timeout_q, timeout_d;

  // Next-state, counters and flag decode; flags follow the next state so they register with it
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    if (soft_rst) begin
      state_d   = S_RESET;
      rst_cnt_d = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_cnt_q == RC_LAST) begin
            state_d   = S_RUN;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RC_W'(1);
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (err) begin
            state_d = S_ERROR;
          end else if (halt) begin
            state_d = S_HALT;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_TIMEOUT;
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT, S_ERROR, S_TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          // Unused encodings fall back into a full reset sequence
          state_d   = S_RESET;
          rst_cnt_d = '0;
          cnt_d     = '0;
        end
      endcase
    end
    core_rst_d = (state_d == S_RESET);
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_HALT);
    err_flag_d = (state_d == S_ERROR);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      rst_cnt_q  <= '0;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      err_flag_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      err_flag_q <= err_flag_d;
      timeout_q  <= timeout_d;
    end
  end

  assign state       = state_q;
  assign cycle_count = cnt_q;
  assign core_rst    = core_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign err_flag    = err_flag_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller sitting between the board/bench clock-reset source and the processor core. It stretches the external reset into a fixed-length core reset, counts executed cycles, and ends the run in a sticky terminal state on core error, core halt, or watchdog timeout. It provides a single status point for run/done/fail, replacing ad-hoc cycle limits in benches.

## Interface
- RST_CYCLES, 2, rising clk edges core_rst stays high after rst_n deasserts; must be >= 1
- MAX_CYCLES, 100004, watchdog limit on RUN-state cycles; must be < 2^CNT_W
- CNT_W, 32, width of cycle_count
- clk  in  1  single system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- soft_rst  in  1  synchronous restart request, active-high
- err  in  1  core error indication, sampled in RUN only
- halt  in  1  core halt indication, sampled in RUN only
- core_rst  out  1  active-high reset to the core
- running  out  1  high only in RUN
- done  out  1  high only in HALT
- err_flag  out  1  high only in ERROR
- timeout  out  1  high only in TIMEOUT
- state  out  3  current state encoding
- cycle_count  out  CNT_W  RUN-state cycles elapsed

## Operation
- States: RESET=0, RUN=1, HALT=2, ERROR=3, TIMEOUT=4; 5-7 unused and must recover to RESET on the next edge.
- rst_n low, asynchronous: state=RESET, rst_cnt=0, cycle_count=0, core_rst=1, running/done/err_flag/timeout=0.
- RESET: rst_cnt increments on each edge. On the edge where rst_cnt==RST_CYCLES-1, go to RUN, clear core_rst and clear rst_cnt. err and halt are ignored.
- RUN: cycle_count increments on every edge, including the edge that leaves RUN. Next-state priority, highest first:
  - soft_rst
  - err -> ERROR
  - halt -> HALT
  - cycle_count==MAX_CYCLES-1 -> TIMEOUT
- HALT, ERROR, TIMEOUT: sticky. cycle_count is frozen, core_rst=0, inputs other than soft_rst and rst_n are ignored.
- soft_rst sampled high in any state goes to RESET on that edge:
  - cycle_count=0, rst_cnt=0, core_rst=1, all flags 0.
  - The RESET sequence then restarts in full.
  - soft_rst held high keeps the block in RESET with rst_cnt at 0.
- Arithmetic: cycle_count is unsigned, CNT_W bits, and never wraps; the TIMEOUT transition happens before overflow by construction. rst_cnt width is clog2(RST_CYCLES)+1.
- Simultaneous err and halt in RUN: ERROR wins. err or halt on the timeout edge: ERROR or HALT wins over TIMEOUT.

## Timing
- All outputs are registered. Only rst_n acts asynchronously, forcing the reset values immediately.
- rst_n deassertion must meet recovery/removal at clk; the bench releases it mid-period.
- core_rst: high for exactly RST_CYCLES rising edges after rst_n release, falling at edge RST_CYCLES.
- First RUN cycle follows that edge. err/halt visible before the next edge causes the terminal state at that edge, with cycle_count=1.
- Latency from err/halt/soft_rst sample to flag/state update: 1 edge.
- Flags are mutually exclusive and exactly one-hot with the state among running/done/err_flag/timeout; RESET asserts none of them.

## Test plan
Bench parameters: RST_CYCLES=2, MAX_CYCLES=10, CNT_W=8.

- Reset sequence: release rst_n at t=201 with clk period 100 and rising edges at 300 and 400 -> core_rst=1 through the edge at 300 and 0 after the edge at 400; state=1 and running=1 after 400.
- Halt: assert halt in the 4th RUN cycle -> at that edge state=2, done=1, cycle_count=4. Holding for 20 more cycles with err pulsed -> no change.
- Priority: err and halt both high in the 3rd RUN cycle -> state=3, err_flag=1, done=0, cycle_count=3.
- Watchdog: no err/halt -> after the 10th RUN edge state=4, timeout=1, cycle_count=10 and frozen. Halt on the 10th edge instead -> state=2, cycle_count=10.
- soft_rst in ERROR: one-cycle pulse -> next edge state=0, core_rst=1, cycle_count=0, flags 0. Two edges later state=1.
- Async reset mid-run: drop rst_n between edges at cycle_count=5 -> core_rst=1, state=0, cycle_count=0 immediately, without waiting for a clk edge.
